// File: rtl/timer_ctrl.sv
// Countdown timer with four reprogrammable interval slots, a free-running
// one-second prescaler, and a three-state IDLE/COUNT/DONE controller.
module timer_ctrl #(
  parameter int CLK_HZ       = 100000000,
  parameter int T_ARM_DEF    = 6,
  parameter int T_DRIVER_DEF = 8,
  parameter int T_PASS_DEF   = 15,
  parameter int T_ALARM_DEF  = 10
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       start_timer,
  input  logic [1:0] interval,
  input  logic       reprogram,
  input  logic [1:0] time_param_sel,
  input  logic [3:0] time_value,
  output logic       one_hz_enable,
  output logic       expired,
  output logic       busy,
  output logic [3:0] remaining
);

  localparam int            PW      = $clog2(CLK_HZ);
  localparam logic [PW-1:0] PRE_MAX = PW'(CLK_HZ - 1);

  typedef enum logic [1:0] {IDLE, COUNT, DONE} state_e;

  state_e          state_q, state_d;
  logic [PW-1:0]   prescaler_q, prescaler_d;
  logic [3:0]      remaining_q, remaining_d;
  logic [3:0][3:0] slots_q, slots_d;
  logic            tick;

  assign tick = (prescaler_q == PRE_MAX);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      prescaler_q <= '0;
      remaining_q <= '0;
      slots_q     <= {4'(T_ALARM_DEF), 4'(T_PASS_DEF), 4'(T_DRIVER_DEF), 4'(T_ARM_DEF)};
    end else begin
      state_q     <= state_d;
      prescaler_q <= prescaler_d;
      remaining_q <= remaining_d;
      slots_q     <= slots_d;
    end
  end

  // A write strobe always aborts, and a start restarts from any state.
  always_comb begin
    state_d = state_q;
    if (reprogram) begin
      state_d = IDLE;
    end else if (start_timer) begin
      state_d = COUNT;
    end else begin
      case (state_q)
        COUNT:   if (tick && (remaining_q <= 4'd1)) state_d = DONE;
        DONE:    state_d = IDLE;
        default: state_d = state_q;
      endcase
    end
  end

  always_comb begin
    prescaler_d = prescaler_q + PW'(1);
    remaining_d = remaining_q;
    slots_d     = slots_q;
    if (reprogram || start_timer || tick) begin
      prescaler_d = '0;
    end
    if (reprogram) begin
      remaining_d = '0;
      slots_d[time_param_sel] = (time_value == 4'd0) ? 4'd1 : time_value;
    end else if (start_timer) begin
      remaining_d = slots_q[interval];
    end else if ((state_q == COUNT) && tick && (remaining_q != 4'd0)) begin
      remaining_d = remaining_q - 4'd1;
    end
  end

  always_comb begin
    one_hz_enable = tick;
    busy          = (state_q == COUNT);
    expired       = (state_q == DONE);
    remaining     = remaining_q;
  end

endmodule

// File: tb/tb_timer_ctrl.sv
// Bench for timer_ctrl at CLK_HZ=4: a vector table drives and checks the
// outputs, while a scoreboard of expected expiry cycles polices the expired pulse.
module tb_timer_ctrl;

  typedef struct {
    logic       start;
    logic [1:0] interval;
    logic       reprog;
    logic [1:0] sel;
    logic [3:0] value;
    int         idle;
    logic       expBusy;
    logic [3:0] expRem;
    logic       expExp;
    int         sbAct;
    int         sbDelay;
  } vec_t;

  logic       clock;
  logic       reset;
  logic       startTimer;
  logic [1:0] intervalSel;
  logic       reprogram;
  logic [1:0] timeParamSel;
  logic [3:0] timeValue;
  logic       oneHz;
  logic       expired;
  logic       busy;
  logic [3:0] remaining;

  int   checks   = 0;
  int   failures = 0;
  int   cyc      = 0;
  int   sb[$];
  vec_t vecs[$];

  timer_ctrl #(.CLK_HZ(4)) dut (
    .clock(clock),
    .reset(reset),
    .start_timer(startTimer),
    .interval(intervalSel),
    .reprogram(reprogram),
    .time_param_sel(timeParamSel),
    .time_value(timeValue),
    .one_hz_enable(oneHz),
    .expired(expired),
    .busy(busy),
    .remaining(remaining)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(posedge clock) cyc++;

  // Every expired pulse must land exactly on the cycle the scoreboard predicts.
  always @(posedge clock) begin
    int expCyc;
    #2;
    if (expired === 1'b1) begin
      checks++;
      if (sb.size() == 0) begin
        failures++;
        $display("[TB] FAIL expiredPulse unexpected at cycle %0d, required none", cyc);
      end else begin
        expCyc = sb.pop_front();
        if (expCyc != cyc) begin
          failures++;
          $display("[TB] FAIL expiredPulse at cycle %0d, required cycle %0d", cyc, expCyc);
        end
      end
    end else if (sb.size() > 0 && cyc > sb[0]) begin
      checks++;
      failures++;
      $display("[TB] FAIL expiredPulse missing at cycle %0d, now cycle %0d", sb[0], cyc);
      void'(sb.pop_front());
    end
  end

  function automatic vec_t mkVec(input int st, input int iv, input int rp, input int sl,
                                 input int vl, input int idl, input int eb, input int er,
                                 input int ee, input int act, input int dly);
    vec_t v;
    v.start    = 1'(st);
    v.interval = 2'(iv);
    v.reprog   = 1'(rp);
    v.sel      = 2'(sl);
    v.value    = 4'(vl);
    v.idle     = idl;
    v.expBusy  = 1'(eb);
    v.expRem   = 4'(er);
    v.expExp   = 1'(ee);
    v.sbAct    = act;
    v.sbDelay  = dly;
    return v;
  endfunction

  task automatic checkValue(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("[TB] FAIL %s got=%0d required=%0d", name, got, want);
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    int driveEdge;
    startTimer   = v.start;
    intervalSel  = v.interval;
    reprogram    = v.reprog;
    timeParamSel = v.sel;
    timeValue    = v.value;
    driveEdge    = cyc + 1;
    if (v.sbAct == 1) begin
      sb.delete();
      sb.push_back(driveEdge + v.sbDelay);
    end else if (v.sbAct == 2) begin
      sb.delete();
    end
    @(posedge clock);
    @(negedge clock);
    startTimer = 1'b0;
    reprogram  = 1'b0;
    repeat (v.idle) @(negedge clock);
  endtask

  task automatic checkOutput(input int idx, input vec_t v);
    checkValue($sformatf("vec%0d busy", idx), 32'(busy), 32'(v.expBusy));
    checkValue($sformatf("vec%0d remaining", idx), 32'(remaining), 32'(v.expRem));
    checkValue($sformatf("vec%0d expired", idx), 32'(expired), 32'(v.expExp));
  endtask

  initial begin
    #100000;
    failures++;
    $display("[TB] FAIL watchdog expired at cycle %0d", cyc);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    int tickCount;
    int lastTick;

    //                st iv rp sl vl idle  b  rem e  act dly
    vecs.push_back(mkVec(1, 0, 0, 0, 0,  0, 1,  6, 0, 1, 24));
    vecs.push_back(mkVec(0, 0, 0, 0, 0,  2, 1,  6, 0, 0,  0));
    vecs.push_back(mkVec(0, 0, 0, 0, 0,  0, 1,  5, 0, 0,  0));
    vecs.push_back(mkVec(0, 0, 0, 0, 0,  7, 1,  3, 0, 0,  0));
    vecs.push_back(mkVec(0, 0, 0, 0, 0, 10, 1,  1, 0, 0,  0));
    vecs.push_back(mkVec(0, 0, 0, 0, 0,  0, 0,  0, 1, 0,  0));
    vecs.push_back(mkVec(0, 0, 0, 0, 0,  0, 0,  0, 0, 0,  0));
    vecs.push_back(mkVec(0, 0, 1, 2, 3,  0, 0,  0, 0, 0,  0));
    vecs.push_back(mkVec(1, 2, 0, 0, 0,  0, 1,  3, 0, 1, 12));
    vecs.push_back(mkVec(0, 0, 0, 0, 0, 10, 1,  1, 0, 0,  0));
    vecs.push_back(mkVec(0, 0, 0, 0, 0,  0, 0,  0, 1, 0,  0));
    vecs.push_back(mkVec(0, 0, 1, 1, 0,  1, 0,  0, 0, 0,  0));
    vecs.push_back(mkVec(1, 1, 0, 0, 0,  0, 1,  1, 0, 1,  4));
    vecs.push_back(mkVec(0, 0, 0, 0, 0,  2, 1,  1, 0, 0,  0));
    vecs.push_back(mkVec(0, 0, 0, 0, 0,  0, 0,  0, 1, 0,  0));
    vecs.push_back(mkVec(0, 0, 1, 1, 8,  0, 0,  0, 0, 0,  0));
    vecs.push_back(mkVec(1, 3, 0, 0, 0,  0, 1, 10, 0, 1, 40));
    vecs.push_back(mkVec(0, 0, 0, 0, 0,  9, 1,  8, 0, 0,  0));
    vecs.push_back(mkVec(1, 1, 0, 0, 0,  0, 1,  8, 0, 1, 32));
    vecs.push_back(mkVec(0, 0, 0, 0, 0, 30, 1,  1, 0, 0,  0));
    vecs.push_back(mkVec(0, 0, 0, 0, 0,  0, 0,  0, 1, 0,  0));
    vecs.push_back(mkVec(1, 0, 0, 0, 0,  0, 1,  6, 0, 1, 24));
    vecs.push_back(mkVec(0, 0, 0, 0, 0,  3, 1,  5, 0, 0,  0));
    vecs.push_back(mkVec(0, 0, 1, 0, 6,  0, 0,  0, 0, 2,  0));
    vecs.push_back(mkVec(0, 0, 0, 0, 0, 30, 0,  0, 0, 0,  0));
    vecs.push_back(mkVec(1, 2, 1, 3, 5,  0, 0,  0, 0, 0,  0));
    vecs.push_back(mkVec(1, 3, 0, 0, 0,  0, 1,  5, 0, 1, 20));
    vecs.push_back(mkVec(0, 0, 0, 0, 0, 19, 0,  0, 1, 0,  0));
    vecs.push_back(mkVec(1, 2, 0, 0, 0,  0, 1,  3, 0, 1, 12));
    vecs.push_back(mkVec(0, 0, 0, 0, 0, 10, 1,  1, 0, 0,  0));
    vecs.push_back(mkVec(1, 1, 0, 0, 0,  0, 1,  8, 0, 1, 32));
    vecs.push_back(mkVec(0, 0, 0, 0, 0, 31, 0,  0, 1, 0,  0));
    vecs.push_back(mkVec(1, 2, 0, 0, 0,  0, 1,  3, 0, 1, 12));
    vecs.push_back(mkVec(0, 0, 0, 0, 0, 11, 0,  0, 1, 0,  0));
    vecs.push_back(mkVec(1, 1, 0, 0, 0,  0, 1,  8, 0, 1, 32));
    vecs.push_back(mkVec(1, 2, 0, 0, 0,  0, 1, 15, 0, 1, 60));
    vecs.push_back(mkVec(1, 3, 0, 0, 0,  0, 1, 10, 0, 1, 40));
    vecs.push_back(mkVec(1, 0, 0, 0, 0,  0, 1,  6, 0, 1, 24));
    vecs.push_back(mkVec(0, 0, 0, 0, 0, 23, 0,  0, 1, 0,  0));

    reset        = 1'b0;
    startTimer   = 1'b0;
    intervalSel  = 2'd0;
    reprogram    = 1'b0;
    timeParamSel = 2'd0;
    timeValue    = 4'd0;

    repeat (2) @(negedge clock);
    checkValue("resetBusy", 32'(busy), 0);
    checkValue("resetRemaining", 32'(remaining), 0);
    checkValue("resetExpired", 32'(expired), 0);
    checkValue("resetTick", 32'(oneHz), 0);
    reset = 1'b1;

    for (int i = 0; i < 34; i++) begin
      applyStimulus(vecs[i]);
      checkOutput(i, vecs[i]);
    end

    // Slot 0 was left at 6; abort that countdown ten cycles in with reset.
    applyStimulus(mkVec(1, 0, 0, 0, 0, 9, 1, 6, 0, 1, 24));
    checkValue("preResetRemaining", 32'(remaining), 4);
    reset = 1'b0;
    sb.delete();
    #1;
    checkValue("midResetBusy", 32'(busy), 0);
    checkValue("midResetRemaining", 32'(remaining), 0);
    checkValue("midResetExpired", 32'(expired), 0);
    checkValue("midResetTick", 32'(oneHz), 0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      checkValue($sformatf("heldResetTick%0d", i), 32'(oneHz), 0);
    end
    reset = 1'b1;

    for (int i = 34; i < vecs.size(); i++) begin
      applyStimulus(vecs[i]);
      checkOutput(i, vecs[i]);
    end

    tickCount = 0;
    lastTick  = -1;
    for (int i = 0; i < 16; i++) begin
      @(negedge clock);
      if (oneHz === 1'b1) begin
        if (lastTick >= 0) checkValue("idleTickGap", 32'(cyc - lastTick), 4);
        lastTick = cyc;
        tickCount++;
      end
    end
    checkValue("idleTickCount", 32'(tickCount), 4);

    repeat (4) @(negedge clock);
    checkValue("scoreboardDrained", 32'(sb.size()), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/timer_ctrl.md
TIMER_CTRL -- requirements
Module: timer_ctrl

Interface
REQ-001 Parameter CLK_HZ, default 100000000: clock cycles per one-second tick; legal range 2 or more.
REQ-002 Parameter T_ARM_DEF, default 6: reset value of interval slot 0 (arm delay), in seconds.
REQ-003 Parameter T_DRIVER_DEF, default 8: reset value of slot 1 (driver door delay).
REQ-004 Parameter T_PASS_DEF, default 15: reset value of slot 2 (passenger door delay).
REQ-005 Parameter T_ALARM_DEF, default 10: reset value of slot 3 (siren on time).
REQ-006 clock  input  1  single system clock; all state updates on its rising edge.
REQ-007 reset  input  1  asynchronous, active-low reset.
REQ-008 start_timer  input  1  single-cycle request to load and start the countdown.
REQ-009 interval  input  2  slot to load on start_timer (0 arm, 1 driver, 2 passenger, 3 alarm).
REQ-010 reprogram  input  1  single-cycle write strobe for a slot value.
REQ-011 time_param_sel  input  2  slot written on reprogram.
REQ-012 time_value  input  4  seconds written on reprogram.
REQ-013 one_hz_enable  output  1  one-cycle tick once per CLK_HZ cycles.
REQ-014 expired  output  1  registered one-cycle pulse at end of countdown.
REQ-015 busy  output  1  high while a countdown is running.
REQ-016 remaining  output  4  current countdown value, in seconds.

Function
REQ-017 Four 4-bit slot registers SHALL hold the interval lengths; interval and time_param_sel index them directly.
REQ-018 reprogram SHALL write time_value into slot time_param_sel at the clock edge; time_value 0 is stored as 1.
REQ-019 reprogram SHALL abort any running countdown: busy 0, remaining 0, prescaler 0, and no expired pulse.
REQ-020 reprogram and start_timer in the same cycle: reprogram wins and start_timer is ignored.
REQ-021 The prescaler SHALL count 0..CLK_HZ-1 and wrap to 0; one_hz_enable is high exactly while the prescaler equals CLK_HZ-1.
REQ-022 The prescaler SHALL run freely in IDLE so that one_hz_enable keeps ticking for status blink.
REQ-023 A start_timer accepted at edge E0 SHALL load remaining with the selected slot value (the value before any same-edge write), clear the prescaler, and set busy.
REQ-024 State machine has three states: IDLE, COUNT, DONE.
REQ-025 IDLE->COUNT on start_timer; COUNT->DONE at the tick edge where remaining goes 1->0; DONE->IDLE after one cycle.
REQ-026 In COUNT, remaining SHALL decrement by 1 at each edge where one_hz_enable is high; it never wraps below 0.
REQ-027 expired SHALL be high only in DONE, i.e. for the single cycle after edge E0 + T*CLK_HZ, where T is the loaded value.
REQ-028 busy SHALL be high in COUNT only.
REQ-029 start_timer in COUNT or DONE SHALL restart the countdown per REQ-023; in DONE, expired still completes its one cycle.
REQ-030 start_timer at the same edge as the final decrement SHALL reload and stay in COUNT; no expired pulse is generated.
REQ-031 Slot writes during COUNT SHALL NOT change remaining; the new value applies to the next start.

Reset
REQ-032 While reset is low, state SHALL be IDLE, prescaler 0, remaining 0, expired 0, busy 0, and slots SHALL hold their T_*_DEF values.
REQ-033 Reset asserted mid-countdown SHALL abort it immediately with no expired pulse; operation resumes at the first edge after release.

Verification (CLK_HZ=4)
REQ-034 Release reset, start_timer with interval=0 -> busy=1, remaining=6; remaining steps 6..1 every 4 cycles; expired is high for exactly 1 cycle, 24 cycles after the start edge; then busy=0.
REQ-035 reprogram sel=2 value=3, then start interval=2 -> expired 12 cycles after start; reprogram sel=1 value=0, then start interval=1 -> expired after 4 cycles.
REQ-036 start interval=3, then re-assert start_timer interval=1 after 10 cycles -> remaining=8 and expired 32 cycles after the second start, with no earlier pulse.
REQ-037 start interval=0, reprogram after 5 cycles -> busy=0 and remaining=0 next cycle; no expired pulse; start_timer and reprogram in the same cycle -> write only, no start.
REQ-038 Assert reset at cycle 10 of a countdown -> all outputs 0 at once and slots restored to 6/8/15/10; idle one_hz_enable pulses every 4 cycles.
